alu_seq: RTL

- Parametrised, handshaked successor to the 16-bit datapath ALU.
- Performs add, sub, unsigned multiply, unsigned divide and bitwise ops on WIDTH-bit operands.
- Multiply and divide are iterative, one bit per cycle; all other ops complete in one cycle.
- Sits between the register file and writeback; the controller issues on start and retires on done.

---
 rtl/alu_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: add/sub/logic retire in one cycle, mul/div iterate one bit per cycle.
// Define MUL_SIGNED_EN to make opcode 111 a signed multiply; otherwise opcode 111 returns 0.
module alu_seq #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           opcode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result_low,
  output logic [2*WIDTH-1:0]   result_high,
  output logic                 div_by_zero
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010, OP_DIV  = 3'b011,
    OP_AND = 3'b100, OP_OR  = 3'b101, OP_XOR = 3'b110, OP_SMUL = 3'b111
  } op_t;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t             state_q;
  op_t                op_q;
  logic [WIDTH-1:0]   opnd_q;   // multiplicand or divisor
  logic [WIDTH-1:0]   hi_q;     // product high half / partial remainder
  logic [WIDTH-1:0]   lo_q;     // multiplier / quotient being shifted in
  logic [CNT_W-1:0]   cnt_q;

  logic               is_multi;
  logic [W2-1:0]      single_res;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [W2-1:0]      product;

`ifdef MUL_SIGNED_EN
  logic               neg_q;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    single_res = '0;
    is_multi   = (opcode == OP_MUL) || (opcode == OP_DIV);
    case (op_t'(opcode))
      OP_ADD:  single_res = W2'({1'b0, a} + {1'b0, b});
      OP_SUB:  single_res = {{WIDTH{1'b0}}, a} - {{WIDTH{1'b0}}, b};
      OP_AND:  single_res = W2'(a & b);
      OP_OR:   single_res = W2'(a | b);
      OP_XOR:  single_res = W2'(a ^ b);
      default: single_res = '0;
    endcase

    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = div_shift >= {1'b0, opnd_q};
    product   = {hi_q, lo_q};

`ifdef MUL_SIGNED_EN
    if (opcode == OP_SMUL) is_multi = 1'b1;
    a_mag = a[WIDTH-1] ? -a : a;
    b_mag = b[WIDTH-1] ? -b : b;
    if (neg_q) product = -{hi_q, lo_q};
`endif
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      opnd_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      result_low  <= '0;
      result_high <= '0;
`ifdef MUL_SIGNED_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q        <= op_t'(opcode);
            opnd_q      <= b;
            cnt_q       <= '0;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
`ifdef MUL_SIGNED_EN
            neg_q       <= 1'b0;
`endif
            if (is_multi) begin
              state_q <= CALC;
              hi_q    <= '0;
              lo_q    <= a;
`ifdef MUL_SIGNED_EN
              if (opcode == OP_SMUL) begin
                lo_q   <= a_mag;
                opnd_q <= b_mag;
                neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
              end
`endif
            end else begin
              state_q      <= FIN;
              {hi_q, lo_q} <= single_res;
            end
          end
        end

        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (op_q == OP_DIV) begin
            hi_q <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], div_ge};
          end else begin
            hi_q <= mul_sum[WIDTH:1];
            lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
          end
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIN;
        end

        FIN: begin
          state_q <= IDLE;
          done    <= 1'b1;
          busy    <= 1'b0;
          if (op_q == OP_DIV) begin
            result_low  <= {{WIDTH{1'b0}}, lo_q};
            result_high <= {{WIDTH{1'b0}}, hi_q};
            div_by_zero <= (opnd_q == '0);
          end else begin
            result_low  <= product;
            result_high <= '0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
